// File: rtl/raster_pkg.sv
// Shared types for the raster scheduler: vertex/triangle layout, scheduler states
// and the geometric cull test used when RASTER_SCHED_CULL_EN is defined.
package raster_pkg;

  localparam int X_IDX = 2;
  localparam int Y_IDX = 1;
  localparam int Z_IDX = 0;

  typedef logic [2:0][8:0] vertex_t;

  typedef struct packed {
    vertex_t v1;
    vertex_t v2;
    vertex_t v3;
    logic    last;
  } tri_t;

  typedef enum logic [2:0] {
    CLEAR_START = 3'd0,
    CLEAR_WAIT  = 3'd1,
    WAIT_TRI    = 3'd2,
    ISSUE       = 3'd3,
    RASTER      = 3'd4,
    FRAME_DONE  = 3'd5
  } sched_state_t;

  function automatic logic [8:0] min3(input logic [8:0] a, input logic [8:0] b,
                                      input logic [8:0] c);
    logic [8:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  // True when the triangle lies fully right of / below the screen or is flat in x or y.
  function automatic logic tri_culled(input tri_t t, input logic [9:0] w, input logic [9:0] h);
    logic [8:0] min_x;
    logic [8:0] min_y;
    logic       flat_x;
    logic       flat_y;
    min_x  = min3(t.v1[X_IDX], t.v2[X_IDX], t.v3[X_IDX]);
    min_y  = min3(t.v1[Y_IDX], t.v2[Y_IDX], t.v3[Y_IDX]);
    flat_x = (t.v1[X_IDX] == t.v2[X_IDX]) && (t.v2[X_IDX] == t.v3[X_IDX]);
    flat_y = (t.v1[Y_IDX] == t.v2[Y_IDX]) && (t.v2[Y_IDX] == t.v3[Y_IDX]);
    return ({1'b0, min_x} >= w) || ({1'b0, min_y} >= h) || flat_x || flat_y;
  endfunction

endpackage

// File: rtl/tri_fifo.sv
// Synchronous triangle FIFO; head is read straight from storage, so a pushed entry
// becomes visible only the cycle after it was written.
module tri_fifo
  import raster_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  tri_t push_data,
  input  logic pop,
  output tri_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  tri_t        mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointers carry an extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/raster_scheduler.sv
// Frame sequencer for the rasterizer: clear, issue queued triangles, swap at vblank.
// Define RASTER_SCHED_CULL_EN to drop off-screen and degenerate triangles before issue.
module raster_scheduler
  import raster_pkg::*;
#(
  parameter int WIDTH      = 360,
  parameter int HEIGHT     = 360,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [26:0] tri_vert1_in,
  input  logic [26:0] tri_vert2_in,
  input  logic [26:0] tri_vert3_in,
  input  logic        tri_last_in,
  input  logic        tri_valid_in,
  output logic        tri_ready_out,
  output logic [26:0] vert1,
  output logic [26:0] vert2,
  output logic [26:0] vert3,
  output logic        valid_tri,
  input  logic        raster_done_in,
  output logic        clear_start_out,
  input  logic        clear_done_in,
  input  logic        new_frame_in,
  output logic        new_frame,
  output logic        obj_done,
  output logic [15:0] tri_count_out,
  output logic [7:0]  late_frames_out
);

  localparam logic [9:0] WIDTH_L  = 10'(WIDTH);
  localparam logic [9:0] HEIGHT_L = 10'(HEIGHT);
`ifdef RASTER_SCHED_CULL_EN
  localparam logic CULL_EN = 1'b1;
`else
  localparam logic CULL_EN = 1'b0;
`endif

  sched_state_t state;
  logic         cur_last;
  tri_t         in_tri;
  tri_t         head;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic         cull;

  assign in_tri        = {tri_vert1_in, tri_vert2_in, tri_vert3_in, tri_last_in};
  assign tri_ready_out = !full && !rst_in;
  assign push          = tri_valid_in && tri_ready_out;
  assign pop           = (state == WAIT_TRI) && !empty;
  assign cull          = CULL_EN && tri_culled(head, WIDTH_L, HEIGHT_L);

  tri_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (push),
    .push_data (in_tri),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Scheduler FSM; all outputs are registered and pulses default low each cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= CLEAR_START;
      cur_last        <= 1'b0;
      vert1           <= 27'd0;
      vert2           <= 27'd0;
      vert3           <= 27'd0;
      valid_tri       <= 1'b0;
      clear_start_out <= 1'b0;
      new_frame       <= 1'b0;
      obj_done        <= 1'b0;
      tri_count_out   <= 16'd0;
      late_frames_out <= 8'd0;
    end else begin
      valid_tri       <= 1'b0;
      clear_start_out <= 1'b0;
      new_frame       <= 1'b0;

      // A boundary outside FRAME_DONE means the display repeats the front buffer.
      if (new_frame_in && (state != FRAME_DONE) && (late_frames_out != 8'hFF)) begin
        late_frames_out <= late_frames_out + 8'd1;
      end

      case (state)
        CLEAR_START: begin
          clear_start_out <= 1'b1;
          state           <= CLEAR_WAIT;
        end
        CLEAR_WAIT: begin
          if (clear_done_in) begin
            state <= WAIT_TRI;
          end
        end
        WAIT_TRI: begin
          if (!empty) begin
            if (cull) begin
              if (head.last) begin
                obj_done <= 1'b1;
                state    <= FRAME_DONE;
              end
            end else begin
              vert1     <= head.v1;
              vert2     <= head.v2;
              vert3     <= head.v3;
              cur_last  <= head.last;
              valid_tri <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (tri_count_out != 16'hFFFF) begin
            tri_count_out <= tri_count_out + 16'd1;
          end
          state <= RASTER;
        end
        RASTER: begin
          if (raster_done_in) begin
            if (cur_last) begin
              obj_done <= 1'b1;
              state    <= FRAME_DONE;
            end else begin
              state <= WAIT_TRI;
            end
          end
        end
        FRAME_DONE: begin
          if (new_frame_in) begin
            new_frame     <= 1'b1;
            obj_done      <= 1'b0;
            tri_count_out <= 16'd0;
            state         <= CLEAR_START;
          end
        end
        default: begin
          state <= CLEAR_START;
        end
      endcase
    end
  end

endmodule

// File: doc/raster_scheduler.md
Name: raster_scheduler

Overview:
- Sequences the triangle rasterizer and its double-buffered z/frame buffer across video frames.
- Accepts triangles from the transform stage into a small FIFO and issues them one at a time to the rasterizer.
- Starts a back-buffer clear at each frame start.
- Issues the buffer-swap pulse only when a frame is fully drawn and video timing reaches a frame boundary.

Parameters:
- WIDTH, 360, screen width in pixels; used for optional culling.
- HEIGHT, 360, screen height in pixels; used for optional culling.
- FIFO_DEPTH, 8, triangle FIFO entries; power of two, 2..64.

Ports:
- clk_in  input  1  system clock; single clock domain.
- rst_in  input  1  synchronous, active-high reset.
- tri_vert1_in/tri_vert2_in/tri_vert3_in  input  3x9 each  vertex: [2]=x, [1]=y, [0]=z.
- tri_last_in  input  1  marks the final triangle of the frame.
- tri_valid_in  input  1  input triangle valid.
- tri_ready_out  output  1  FIFO can accept; equals !full, forced 0 while rst_in.
- vert1/vert2/vert3  output  3x9 each  registered vertices to the rasterizer.
- valid_tri  output  1  one-cycle issue pulse to the rasterizer.
- raster_done_in  input  1  one-cycle pulse: rasterizer returned to its receive state.
- clear_start_out  output  1  one-cycle pulse to start the back-buffer clear engine.
- clear_done_in  input  1  one-cycle pulse: clear finished.
- new_frame_in  input  1  one-cycle pulse from video timing at vblank start.
- new_frame  output  1  one-cycle buffer-swap pulse to the rasterizer.
- obj_done  output  1  high while in FRAME_DONE.
- tri_count_out  output  16  triangles issued in the current frame.
- late_frames_out  output  8  saturating count of missed frame boundaries.

Behaviour:
- Handshake: a triangle is pushed when tri_valid_in && tri_ready_out. The FIFO stores {v1,v2,v3,last} as 82 bits. It is popped only on the WAIT_TRI→ISSUE transition.
- Reset: every output is 0, the FIFO is emptied, counters are 0, and state=CLEAR_START. Reset asserted mid-operation aborts everything with identical results; an in-flight rasterizer triangle is abandoned.
- State machine:
  - CLEAR_START: pulse clear_start_out for 1 cycle, then go to CLEAR_WAIT.
  - CLEAR_WAIT: on clear_done_in, go to WAIT_TRI.
  - WAIT_TRI: if the FIFO is not empty, pop the head, register the vertices, and go to ISSUE. The FIFO keeps accepting input while clearing.
  - ISSUE: valid_tri=1 for exactly this cycle; increment tri_count_out (saturating at 0xFFFF); go to RASTER.
  - RASTER: vert1..3 stay stable. On raster_done_in, go to FRAME_DONE if the issued triangle had last=1, otherwise go to WAIT_TRI.
  - FRAME_DONE: obj_done=1. On new_frame_in, new_frame=1 on the next cycle for 1 cycle, tri_count_out resets to 0, and state goes to CLEAR_START.
- Latency: pop to valid_tri is 1 cycle. Swap pulse is 1 cycle after new_frame_in. Minimum issue-to-issue interval is 3 cycles plus rasterizer time.
- Late frames: new_frame_in arriving in any state other than FRAME_DONE increments late_frames_out (saturating at 255). In that case there is no swap and the display repeats the front buffer.
- Simultaneous events:
  - new_frame_in in the same cycle as the RASTER→FRAME_DONE transition counts as late; the swap waits for the next boundary.
  - raster_done_in outside RASTER is ignored.
  - clear_done_in outside CLEAR_WAIT is ignored.
- FIFO boundaries:
  - Full: tri_ready_out=0; the upstream stage holds its data.
  - Empty in WAIT_TRI: stay in WAIT_TRI; no issue.
  - Push and pop in the same cycle: both occur and occupancy is unchanged.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.

Optional Feature:
- Macro: RASTER_SCHED_CULL_EN.
- When defined, a popped triangle is discarded without issue if either condition holds:
  - min(x) >= WIDTH or min(y) >= HEIGHT;
  - all three x values are equal or all three y values are equal (degenerate).
- A culled triangle takes the WAIT_TRI→WAIT_TRI path in 1 cycle and tri_count_out is unchanged. If the culled triangle has last=1, go directly to FRAME_DONE.
- When undefined, every triangle is issued.

Decomposition:
- Package raster_pkg contains:
  - vertex_t, an array [2:0] of 9-bit logic;
  - tri_t, a struct {v1,v2,v3,last};
  - sched_state_t, the enum of the six states;
  - constants X_IDX=2, Y_IDX=1, Z_IDX=0.
- Sub-module tri_fifo: a synchronous FIFO of tri_t, parameterised on depth, with full/empty outputs and no fall-through.

Test Plan:
- Reset release → clear_start_out pulses at cycle 1. After clear_done_in, push 3 triangles (the last with last=1), each answered by raster_done_in 10 cycles after valid_tri. Expect 3 valid_tri pulses and tri_count_out=3; then new_frame_in → new_frame pulse 1 cycle later → clear_start_out.
- new_frame_in pulsed during RASTER → late_frames_out=1, no new_frame pulse; a later new_frame_in in FRAME_DONE swaps normally.
- With the rasterizer stalled, push 9 triangles at FIFO_DEPTH=8 → tri_ready_out=0 after the 8th accepted push; it re-asserts the cycle after the first pop.
- Assert rst_in in RASTER with 4 triangles queued → outputs 0, FIFO empty, clear_start_out pulses after release, and an old raster_done_in is ignored.
- With RASTER_SCHED_CULL_EN: triangle x={400,410,420} last=1 → no valid_tri, direct entry to FRAME_DONE, tri_count_out=0.
- Push 256+ late boundaries → late_frames_out saturates at 255.
